branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the 3-stage RISC-V core (FD, X, MW). It sits beside the control logic. In the FD stage it returns a same-cycle taken/not-taken guess for a conditional branch, which the control logic uses for its predicted-path PC select. In the X stage it consumes the resolved branch outcome to train a direct-mapped, tagged table of 2-bit saturating counters. It also tracks branch and mispredict statistics for the CSR/MMIO counters.

## Interface
Parameters:
- `LINES`, default 32: number of table entries; power of 2, ≥2. `IDX_W = log2(LINES)`.
- `PC_W`, default 32: PC width.

Ports:
- `clk`, input, 1: core clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `bp_enable`, input, 1: predictor enable.
- `pc_guess`, input, PC_W: PC of the FD-stage instruction.
- `is_br_guess`, input, 1: FD-stage instruction is a conditional branch (opcode 0x63).
- `flush_fd`, input, 1: the FD-stage instruction is being killed this cycle.
- `pc_check`, input, PC_W: PC of the X-stage instruction.
- `is_br_check`, input, 1: X-stage instruction is a conditional branch.
- `br_taken_check`, input, 1: resolved outcome of the X-stage branch.
- `pred_taken`, output, 1: combinational FD-stage prediction.
- `mispredict`, output, 1: combinational; the X-stage branch resolved opposite to its FD-stage prediction.
- `branch_count`, output, 32: number of resolved branches.
- `mispredict_count`, output, 32: number of mispredicted branches.

## Operation
- Address split:
  - index = `pc[IDX_W+1:2]`
  - tag = `pc[PC_W-1:IDX_W+2]`
  - `pc[1:0]` is ignored.
- Each entry holds `valid`, `tag`, and a 2-bit counter `ctr`:
  - 00 = strong not-taken
  - 01 = weak not-taken
  - 10 = weak taken
  - 11 = strong taken
- Lookup (combinational): `hit_g = valid[idx_g] && tag[idx_g] == tag_g`, and `pred_taken = bp_enable && is_br_guess && hit_g && ctr[idx_g][1]`. A miss predicts not-taken.
- Prediction pipeline register (`pred_x`): on every rising edge, `pred_x <= flush_fd ? 0 : pred_taken`.
- `mispredict = is_br_check && (br_taken_check != pred_x)`.
- Update, on a rising edge when `is_br_check && bp_enable`:
  - Hit: saturating increment if taken, decrement if not-taken. 11 stays 11 on taken; 00 stays 00 on not-taken.
  - Miss (including an invalid entry): allocate. Set valid=1, write the tag, and set `ctr = taken ? 10 : 01`. This overwrites any prior occupant.
- When `bp_enable` = 0:
  - The table is frozen and `pred_taken` is 0.
  - `pred_x` therefore captures 0, so a taken branch still counts as a mispredict.
- Statistics, on a rising edge:
  - `branch_count` increments when `is_br_check`.
  - `mispredict_count` increments when `mispredict`.
  - Both are unsigned 32-bit and wrap from 0xFFFFFFFF to 0.
  - Both count regardless of `bp_enable`.
- Same-index read/write in one cycle: the FD lookup sees the pre-edge entry. There is no write-to-read bypass. The update becomes visible to lookups in the following cycle.

## Timing
- Prediction latency is 0 cycles: `pred_taken` settles combinationally from `pc_guess` within the same cycle, before the control logic samples it.
- Training latency is 1 cycle: an X-stage outcome at edge N is visible to lookups after edge N.
- `pred_x` lags `pred_taken` by exactly one cycle, matching FD→X advance. There is no stall path; every edge advances.
- Reset (asynchronous, takes effect immediately, independent of `clk`):
  - All `valid` = 0, `pred_x` = 0, both counters = 0.
  - Tags and ctrs need not be cleared.
- Reset values of outputs:
  - `pred_taken` = 0 and `mispredict` = 0, given `pred_x` = 0 and `br_taken_check` = 0 or `is_br_check` = 0.
  - `branch_count` = 0 and `mispredict_count` = 0.
- Reset asserted mid-update: the update is discarded. Post-reset state is exactly the reset state.
- Reset deassertion is synchronised externally. The first update is taken on the first rising edge with `rst` = 0.

## Test plan
- Reset/cold miss: after reset, `pc_guess`=0x0000_1000 with `is_br_guess`=1 → `pred_taken`=0. Then the branch resolves taken in X → `mispredict`=1, `branch_count`=1, `mispredict_count`=1, entry idx 0 ctr=10. Next lookup of 0x1000 → `pred_taken`=1.
- Saturation: train 0x1000 taken 4 times → ctr=11. Then one not-taken → ctr=10, still predicts taken. A second not-taken → ctr=01, predicts not-taken.
- Aliasing: 0x1000 allocated taken. With LINES=32, 0x1080 shares idx 0 with a different tag → predicts not-taken (miss). Resolve 0x1080 not-taken → entry replaced with ctr=01, and 0x1000 now misses → `pred_taken`=0.
- Flush and disable:
  - `flush_fd`=1 while `pred_taken`=1 → next cycle `pred_x`=0, so a taken resolve flags `mispredict`=1.
  - With `bp_enable`=0 → `pred_taken`=0 for a trained entry, and updates leave ctr unchanged.
- Same-cycle index collision: the FD lookup of 0x1000 while X resolves 0x1000 not-taken from ctr=10 → this cycle `pred_taken`=1. The next cycle's lookup → 0.
- Counter wrap and async reset:
  - Force `mispredict_count`=0xFFFFFFFF, then one mispredict → 0.
  - Assert `rst` between clock edges → all counters are 0 and the trained entry misses immediately, without waiting for `clk`.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped, tagged table of 2-bit saturating counters: same-cycle FD-stage
// prediction, X-stage training, and branch/mispredict statistics.
module branch_predictor #(
  parameter int LINES = 32,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bp_enable,
  input  logic [PC_W-1:0] pc_guess,
  input  logic            is_br_guess,
  input  logic            flush_fd,
  input  logic [PC_W-1:0] pc_check,
  input  logic            is_br_check,
  input  logic            br_taken_check,
  output logic            pred_taken,
  output logic            mispredict,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];
  ctr_t             ctr_q [LINES];
  ctr_t             ctr_d [LINES];
  logic             pred_x_q, pred_x_d;
  logic [31:0]      branch_count_q, branch_count_d;
  logic [31:0]      mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0] idx_g, idx_c;
  logic [TAG_W-1:0] tag_g, tag_c;
  logic             hit_g, hit_c;

  always_comb begin
    idx_g = pc_guess[IDX_W+1:2];
    tag_g = pc_guess[PC_W-1:IDX_W+2];
    idx_c = pc_check[IDX_W+1:2];
    tag_c = pc_check[PC_W-1:IDX_W+2];
    hit_g = valid_q[idx_g] && (tag_q[idx_g] == tag_g);
    hit_c = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
    // Lookup reads pre-edge state only; a same-index update shows up next cycle.
    pred_taken = bp_enable && is_br_guess && hit_g && ctr_q[idx_g][1];
    mispredict = is_br_check && (br_taken_check != pred_x_q);
  end

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    ctr_d   = ctr_q;
    if (is_br_check && bp_enable) begin
      if (hit_c) begin
        if (br_taken_check && ctr_q[idx_c] != CTR_ST) begin
          ctr_d[idx_c] = ctr_q[idx_c] + 2'd1;
        end else if (!br_taken_check && ctr_q[idx_c] != CTR_SNT) begin
          ctr_d[idx_c] = ctr_q[idx_c] - 2'd1;
        end
      end else begin
        valid_d[idx_c] = 1'b1;
        tag_d[idx_c]   = tag_c;
        ctr_d[idx_c]   = br_taken_check ? CTR_WT : CTR_WNT;
      end
    end
    pred_x_d           = flush_fd ? 1'b0 : pred_taken;
    branch_count_d     = branch_count_q + {31'd0, is_br_check};
    mispredict_count_d = mispredict_count_q + {31'd0, mispredict};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q            <= '0;
      pred_x_q           <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      valid_q            <= valid_d;
      pred_x_q           <= pred_x_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // NOTE: tag/counter storage is left unreset; a cleared valid bit already hides stale contents.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    ctr_q <= ctr_d;
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by random
// traffic, all compared against a table model built from ints and plain arithmetic.
module tb_branch_predictor;

  localparam int LINES = 32;
  localparam int IDX_W = 5;

  logic        clk;
  logic        rst;
  logic        bp_enable;
  logic [31:0] pc_guess;
  logic        is_br_guess;
  logic        flush_fd;
  logic [31:0] pc_check;
  logic        is_br_check;
  logic        br_taken_check;
  logic        pred_taken;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predictor #(.LINES(LINES), .PC_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .bp_enable        (bp_enable),
    .pc_guess         (pc_guess),
    .is_br_guess      (is_br_guess),
    .flush_fd         (flush_fd),
    .pc_check         (pc_check),
    .is_br_check      (is_br_check),
    .br_taken_check   (br_taken_check),
    .pred_taken       (pred_taken),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: strength 0..3 per line, plus stats and the FD->X prediction.
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  int          m_ctr   [LINES];
  bit          m_pred_x;
  logic [31:0] m_br;
  logic [31:0] m_mis;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % LINES);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_predict(input logic [31:0] pc, input bit br, input bit en);
    int i;
    i = m_idx(pc);
    return en && br && m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_pred_x = 1'b0;
    m_br     = 32'd0;
    m_mis    = 32'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive in the low phase, check combinational outputs,
  // clock, advance the model, then check the statistics.
  task automatic cycle(input logic [31:0] pg, input bit bg, input bit fl,
                       input logic [31:0] pcx, input bit bc, input bit tk,
                       input bit en, input string tag);
    bit exp_pred, exp_mis;
    int i;
    @(negedge clk);
    pc_guess = pg; is_br_guess = bg; flush_fd = fl;
    pc_check = pcx; is_br_check = bc; br_taken_check = tk; bp_enable = en;
    #1;
    exp_pred = m_predict(pg, bg, en);
    exp_mis  = bc && (tk != m_pred_x);
    check({tag, ".pred"}, {31'd0, pred_taken}, {31'd0, exp_pred});
    check({tag, ".mis"},  {31'd0, mispredict}, {31'd0, exp_mis});
    @(posedge clk);
    if (bc && en) begin
      i = m_idx(pcx);
      if (m_valid[i] && m_tag[i] == m_tagof(pcx)) begin
        m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                      : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      end else begin
        m_valid[i] = 1'b1;
        m_tag[i]   = m_tagof(pcx);
        m_ctr[i]   = tk ? 2 : 1;
      end
    end
    m_pred_x = fl ? 1'b0 : exp_pred;
    m_br     = m_br + (bc ? 32'd1 : 32'd0);
    m_mis    = m_mis + (exp_mis ? 32'd1 : 32'd0);
    #1;
    check({tag, ".brc"},  branch_count,     m_br);
    check({tag, ".misc"}, mispredict_count, m_mis);
  endtask

  localparam logic [31:0] PC_A = 32'h0000_1000;
  localparam logic [31:0] PC_B = 32'h0000_1080;

  initial begin
    rst = 1'b1; bp_enable = 1'b1;
    pc_guess = PC_A; is_br_guess = 1'b1; flush_fd = 1'b0;
    pc_check = 32'd0; is_br_check = 1'b0; br_taken_check = 1'b0;
    m_reset();
    #12;
    check("reset.pred", {31'd0, pred_taken}, 32'd0);
    check("reset.mis",  {31'd0, mispredict}, 32'd0);
    check("reset.brc",  branch_count,        32'd0);
    check("reset.misc", mispredict_count,    32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss, allocate taken, then hit.
    cycle(PC_A, 1, 0, 32'd0, 0, 0, 1, "cold");
    cycle(32'd0, 0, 0, PC_A, 1, 1, 1, "alloc");
    cycle(PC_A, 1, 0, 32'd0, 0, 0, 1, "hit");

    // Saturate, then walk back down; guess and resolve share PC_A (same-index collision).
    for (int k = 0; k < 4; k++) cycle(PC_A, 1, 0, PC_A, 1, 1, 1, "sat");
    cycle(PC_A, 1, 0, PC_A, 1, 0, 1, "dec1");
    cycle(PC_A, 1, 0, PC_A, 1, 0, 1, "dec2");
    cycle(PC_A, 1, 0, 32'd0, 0, 0, 1, "weak_nt");

    // Retrain taken, then alias with PC_B on index 0.
    cycle(32'd0, 0, 0, PC_A, 1, 1, 1, "retrain");
    cycle(PC_B, 1, 0, 32'd0, 0, 0, 1, "alias_miss");
    cycle(PC_A, 1, 0, PC_B, 1, 0, 1, "alias_repl");
    cycle(PC_A, 1, 0, 32'd0, 0, 0, 1, "alias_evicted");

    // Flush kills a taken prediction; the resolve then mispredicts.
    cycle(32'd0, 0, 0, PC_A, 1, 1, 1, "ft1");
    cycle(32'd0, 0, 0, PC_A, 1, 1, 1, "ft2");
    cycle(PC_A, 1, 1, 32'd0, 0, 0, 1, "flush");
    cycle(32'd0, 0, 0, PC_A, 1, 1, 1, "flush_res");

    // Disabled: no prediction, no training, statistics still count.
    cycle(PC_A, 1, 0, PC_A, 1, 0, 0, "dis1");
    cycle(PC_A, 1, 0, PC_A, 1, 0, 0, "dis2");
    cycle(PC_A, 1, 0, 32'd0, 0, 0, 1, "dis_after");

    // Mispredict counter wrap.
    force dut.mispredict_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispredict_count_q;
    m_mis = 32'hFFFF_FFFF;
    cycle(32'd0, 0, 0, PC_A, 1, 0, 1, "wrap");

    // Random traffic over a small aliasing PC pool.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] pg, pcx;
      pg  = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      pcx = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      cycle(pg, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            pcx, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) != 0, "rand");
    end

    // Asynchronous reset between edges with a trained entry.
    cycle(32'd0, 0, 0, PC_A, 1, 1, 1, "pre_rst");
    @(negedge clk);
    pc_guess = PC_A; is_br_guess = 1'b1; flush_fd = 1'b0;
    is_br_check = 1'b0; br_taken_check = 1'b0; bp_enable = 1'b1;
    #1;
    check("pre_rst.pred", {31'd0, pred_taken}, {31'd0, m_predict(PC_A, 1, 1)});
    #1;
    rst = 1'b1;
    #1;
    m_reset();
    check("arst.pred", {31'd0, pred_taken}, 32'd0);
    check("arst.mis",  {31'd0, mispredict}, 32'd0);
    check("arst.brc",  branch_count,        32'd0);
    check("arst.misc", mispredict_count,    32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle(PC_A, 1, 0, 32'd0, 0, 0, 1, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
